// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - pin-level sequencer for the serial MAC accelerator
// Optional feature macro MAC_SEQ_AUTOREAD_EN: a MAC request is followed by an automatic READ.
module mac_sequencer #(
    parameter int WIDTH       = 16,
    parameter int HALF_PERIOD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               rsp_valid,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic [1:0]         mac_cmd,
    output logic               mac_clk,
    output logic               mac_din,
    input  logic               mac_dout
);
    localparam int ACC_W  = 2 * WIDTH;
    localparam int PERIOD = 2 * HALF_PERIOD;
    localparam int PH_W   = $clog2(PERIOD);
    localparam int BIT_W  = $clog2(ACC_W);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(HALF_PERIOD);
    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(ACC_W - 1);

    localparam logic [1:0] CMD_RST   = 2'b00;
    localparam logic [1:0] CMD_SHIFT = 2'b01;
    localparam logic [1:0] CMD_LOAD  = 2'b10;
    localparam logic [1:0] CMD_SUM   = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SHIFT_AB, S_LOAD, S_READ, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [ACC_W-1:0]   ab_q, ab_d;
    logic [ACC_W-1:0]   cap_q, cap_d;
    logic [1:0]         sync_q, sync_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ACC_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]         mac_cmd_q, mac_cmd_d;
    logic               mac_clk_q, mac_clk_d;
    logic               mac_din_q, mac_din_d;
    logic               period_end;
    logic               busy_d;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        ab_d       = ab_q;
        cap_d      = cap_q;
        sync_d     = {sync_q[0], mac_dout};
        period_end = (ph_q == PH_LAST);

        if (state_q != S_IDLE && state_q != S_DONE) begin
            ph_d  = period_end ? '0 : ph_q + PH_W'(1);
            bit_d = period_end ? bit_q + BIT_W'(1) : bit_q;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    ab_d = {req_a, req_b};
                    case (req_op)
                        2'b00:   state_d = S_CLR;
                        2'b01:   state_d = S_SHIFT_AB;
                        2'b10:   state_d = S_READ;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_CLR:      if (period_end) state_d = S_DONE;
            S_SHIFT_AB: if (period_end && bit_q == BIT_LAST) state_d = S_LOAD;
            S_LOAD: begin
                if (period_end) begin
`ifdef MAC_SEQ_AUTOREAD_EN
                    state_d = S_READ;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_READ: begin
                // Accelerator rotates on the rising edge; sample just before it.
                if (ph_q == PH_SAMPLE) cap_d = {cap_q[ACC_W-2:0], sync_q[1]};
                if (period_end && bit_q == BIT_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            ph_d  = '0;
            bit_d = '0;
        end

        // Pin outputs derive from the next state, so they change only when a period restarts.
        busy_d = (state_d == S_CLR) || (state_d == S_SHIFT_AB) ||
                 (state_d == S_LOAD) || (state_d == S_READ);
        mac_clk_d = busy_d && (ph_d >= PH_HIGH);
        case (state_d)
            S_CLR:      mac_cmd_d = CMD_RST;
            S_SHIFT_AB: mac_cmd_d = CMD_SHIFT;
            S_LOAD:     mac_cmd_d = CMD_LOAD;
            default:    mac_cmd_d = CMD_SUM;
        endcase
        mac_din_d   = (state_d == S_SHIFT_AB) ? ab_d[bit_d] : 1'b0;
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_q == S_READ) && (state_d == S_DONE);
        rsp_data_d  = rsp_valid_d ? cap_q : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            bit_q       <= '0;
            ab_q        <= '0;
            cap_q       <= '0;
            sync_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            mac_cmd_q   <= CMD_SUM;
            mac_clk_q   <= 1'b0;
            mac_din_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            bit_q       <= bit_d;
            ab_q        <= ab_d;
            cap_q       <= cap_d;
            sync_q      <= sync_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mac_cmd_q   <= mac_cmd_d;
            mac_clk_q   <= mac_clk_d;
            mac_din_q   <= mac_din_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mac_cmd   = mac_cmd_q;
    assign mac_clk   = mac_clk_q;
    assign mac_din   = mac_din_q;
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- On-board controller that drives the serial MAC accelerator's 4-wire pin interface: mac_cmd[1:0], gated serial clock mac_clk, mac_din, and return data mac_dout.
- Accepts parallel CLEAR / MAC / READ requests over a valid/ready handshake.
- Serialises operands, issues the load strobe, and deserialises the 2*WIDTH-bit accumulator.
- Sits between a host bus/UART bridge and the accelerator pins.

Parameters:
- WIDTH, 16, operand width; accumulator is 2*WIDTH.
- HALF_PERIOD, 4, clk cycles per mac_clk phase (legal range >= 2); one serial period P = 2*HALF_PERIOD.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer idle; request accepted when req_valid && req_ready at a clk edge.
- req_op  input  2  00 CLEAR, 01 MAC, 10 READ, 11 NOP.
- req_a  input  WIDTH  multiplicand, captured on accept.
- req_b  input  WIDTH  multiplier, captured on accept.
- rsp_valid  output  1  one-cycle pulse; rsp_data valid.
- rsp_data  output  2*WIDTH  accumulator value from last READ; held until next READ completes.
- mac_cmd  output  2  accelerator command: 00 reset, 01 shift a/b, 10 load sum, 11 shift/rotate sum.
- mac_clk  output  1  serial clock to accelerator.
- mac_din  output  1  serial operand bit.
- mac_dout  input  1  accumulator MSB from accelerator (asynchronous to clk).

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, mac_cmd=11, mac_clk=0, mac_din=0. State IDLE; phase counter and bit counter 0.
- States: IDLE, CLR, SHIFT_AB, LOAD, READ, DONE.
- IDLE: req_ready=1, mac_clk=0, mac_cmd=11 (no clock edges, so harmless). On accept, register op/a/b. Next state: CLR, SHIFT_AB, or READ; NOP goes to DONE.
- Serial period, each P cycles:
  - Low phase: HALF_PERIOD cycles, mac_clk=0.
  - High phase: HALF_PERIOD cycles, mac_clk=1.
  - mac_cmd and mac_din change only on the first cycle of a low phase, never while mac_clk=1.
  - mac_clk is a registered output; no combinational gating.
- CLR: mac_cmd=00 for exactly 1 period, then DONE.
- SHIFT_AB: mac_cmd=01 for 2*WIDTH periods.
  - mac_din order: b[0] .. b[WIDTH-1], then a[0] .. a[WIDTH-1].
  - Then LOAD.
- LOAD: mac_cmd=10 for exactly 1 period (sum <= a*b + sum, modulo 2^(2*WIDTH) in the accelerator), then DONE.
- READ: mac_cmd=11 for 2*WIDTH periods.
  - mac_dout passes through a 2-flop synchroniser.
  - The synchronised value is sampled on the last cycle of each low phase and shifted into a capture register, MSB first.
  - The accelerator rotates its sum, so after 2*WIDTH edges its accumulator is unchanged: READ is non-destructive.
  - Then DONE.
- DONE: one cycle.
  - mac_clk=0, mac_cmd=11.
  - For READ: rsp_data <= capture register and rsp_valid=1 in this cycle.
  - Next state IDLE; req_ready=1 from the following cycle.
- Latency from accept cycle to DONE cycle, exclusive:
  - CLR: P.
  - MAC: (2*WIDTH+1)*P.
  - READ: 2*WIDTH*P.
  - NOP: 0.
- req_ready=0 in every non-IDLE state. req_valid while busy is ignored and must be held by the requester. No queuing.
- rsp_valid never asserts for CLEAR, MAC or NOP.
- Reset mid-operation: next cycle all outputs return to reset values. The accelerator contents are then undefined; the host must issue CLEAR. Reset takes priority over accept in the same cycle.
- Arithmetic is performed only by the accelerator; the sequencer holds no accumulator.

Optional Feature:
- MAC_SEQ_AUTOREAD_EN defined:
  - After LOAD, the sequencer goes directly to READ instead of DONE, so a MAC request returns the new accumulator via rsp_valid/rsp_data.
  - MAC latency becomes (4*WIDTH+1)*P.
- Undefined: MAC returns no response; the READ state is reachable only via req_op=10.

Test Plan (WIDTH=16, HALF_PERIOD=4, bench contains a behavioural accelerator model on the pins):
- Reset, CLEAR, READ -> rsp_data=0x00000000; rsp_valid high exactly 1 cycle, 256 cycles after READ accept.
- CLEAR; MAC a=3,b=5; READ -> rsp_data=0x0000000F. MAC accept-to-DONE = 264 cycles; exactly 33 mac_clk rising edges, last one with mac_cmd=10.
- CLEAR; MAC 0xFFFF*0xFFFF twice; READ -> 0xFFFC0002 (wrap modulo 2^32); READ again -> same value (non-destructive).
- Assert req_valid with op=MAC while a READ is in progress -> req_ready=0 throughout, no extra mac_clk edges; request accepted the cycle after DONE.
- Assert reset at the 10th mac_clk edge of a MAC -> next cycle mac_clk=0, mac_cmd=11, req_ready=1; then CLEAR + READ -> 0.
- Pin checker across all tests: mac_cmd/mac_din never change while mac_clk=1; NOP -> no mac_clk edges, req_ready back after 1 cycle. With MAC_SEQ_AUTOREAD_EN: MAC 7*9 from clear -> rsp_data=0x3F.
